// File: rtl/seg_scan_if.sv
// seg_scan_if: valid/ready frame transfer from the 7-segment decode stage into seg_scan.
interface seg_scan_if #(
    parameter int NDIG = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [7*NDIG-1:0] in_seg;
    logic [NDIG-1:0]   in_dp;
    modport master (output in_valid, in_seg, in_dp, input in_ready);
    modport slave  (input in_valid, in_seg, in_dp, output in_ready);
endinterface

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed seven-segment scanner; new frames take effect only at frame boundaries.
// Defining SEG_SCAN_MASK_EN adds i_en_mask to blank individual digits without changing slot timing.
module seg_scan #(
    parameter int NDIG  = 8,
    parameter int DWELL = 1000,
    parameter int GAP   = 16
) (
    input  logic            clk,
    input  logic            rst,
    seg_scan_if.slave       s,
`ifdef SEG_SCAN_MASK_EN
    input  logic [NDIG-1:0] i_en_mask,
`endif
    output logic [NDIG-1:0] o_an,
    output logic [6:0]      o_seg,
    output logic            o_dp,
    output logic            o_frame_done
);
    localparam int MX = (DWELL > GAP) ? DWELL : GAP;
    localparam int CW = (MX > 1) ? $clog2(MX) : 1;
    localparam int IW = $clog2(NDIG);
    typedef enum logic {BLANK, SHOW} state_t;
    state_t            r_state, w_nstate;
    logic [CW-1:0]     r_cnt, w_ncnt;
    logic [IW-1:0]     r_idx, w_nidx;
    logic [7*NDIG-1:0] r_disp_seg, r_pend_seg, w_ndisp_seg;
    logic [NDIG-1:0]   r_disp_dp, r_pend_dp, w_ndisp_dp, w_en;
    logic              r_ready, w_last, w_wrap, w_commit, w_show;
    assign s.in_ready = r_ready;
`ifdef SEG_SCAN_MASK_EN
    assign w_en = i_en_mask;
`else
    assign w_en = '1;
`endif
    // Outputs are registered from next-state values so they line up with the FSM phase.
    always_comb begin
        w_last      = (r_state == SHOW) ? (r_cnt == CW'(DWELL - 1)) : (r_cnt == CW'(GAP - 1));
        w_nstate    = w_last ? ((r_state == SHOW) ? BLANK : SHOW) : r_state;
        w_ncnt      = w_last ? '0 : r_cnt + 1'b1;
        w_wrap      = w_last && (r_state == BLANK) && (r_idx == IW'(NDIG - 1));
        w_nidx      = (w_last && r_state == BLANK) ? (w_wrap ? '0 : r_idx + 1'b1) : r_idx;
        w_commit    = w_wrap && !r_ready;
        w_ndisp_seg = w_commit ? r_pend_seg : r_disp_seg;
        w_ndisp_dp  = w_commit ? r_pend_dp : r_disp_dp;
        w_show      = (w_nstate == SHOW) && w_en[w_nidx];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BLANK;
            r_cnt   <= '0;
            r_idx   <= IW'(NDIG - 1);
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            r_idx   <= w_nidx;
        end
    end
    // in_ready doubles as the pending-empty flag, so transfer and commit never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready      <= 1'b1;
            r_pend_seg   <= '1;
            r_pend_dp    <= '0;
            r_disp_seg   <= '1;
            r_disp_dp    <= '0;
            o_an         <= '1;
            o_seg        <= 7'h7F;
            o_dp         <= 1'b1;
            o_frame_done <= 1'b0;
        end else begin
            r_disp_seg   <= w_ndisp_seg;
            r_disp_dp    <= w_ndisp_dp;
            if (w_commit) begin
                r_ready <= 1'b1;
            end else if (s.in_valid && r_ready) begin
                r_pend_seg <= s.in_seg;
                r_pend_dp  <= s.in_dp;
                r_ready    <= 1'b0;
            end
            o_an         <= w_show ? ~(NDIG'(1) << w_nidx) : '1;
            o_seg        <= w_show ? w_ndisp_seg[7*w_nidx +: 7] : 7'h7F;
            o_dp         <= w_show ? ~w_ndisp_dp[w_nidx] : 1'b1;
            o_frame_done <= w_wrap;
        end
    end
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: self-checking bench for seg_scan at NDIG=4, DWELL=4, GAP=2 (24-cycle frame).
module tb_seg_scan;
    localparam int NDIG = 4, DWELL = 4, GAP = 2, SLOT = DWELL + GAP, PER = NDIG * SLOT;
    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
        logic       rdy;
    } vec_t;
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NDIG-1:0] an;
    logic [6:0]      seg;
    logic            dp, fd;
`ifdef SEG_SCAN_MASK_EN
    logic [NDIG-1:0] en_mask = 4'b1010;
`endif
    seg_scan_if #(.NDIG(NDIG)) bus();
    seg_scan #(.NDIG(NDIG), .DWELL(DWELL), .GAP(GAP)) dut (
        .clk(clk),
        .rst(rst),
        .s(bus),
`ifdef SEG_SCAN_MASK_EN
        .i_en_mask(en_mask),
`endif
        .o_an(an),
        .o_seg(seg),
        .o_dp(dp),
        .o_frame_done(fd)
    );
    always #5 clk = ~clk;
    int checks = 0, passed = 0, m = 0;
    logic [6:0]      m_disp [NDIG];
    logic [6:0]      m_pend [NDIG];
    logic [NDIG-1:0] m_ddp = '0, m_pdp = '0;
    logic            m_full = 1'b0;
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
    endtask
    // Expected outputs from elapsed cycles since reset release: slot = digit, first DWELL cycles lit.
    task automatic model_check();
        int q, d;
        logic sh, efd;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic e_dp;
        sh = 1'b0;
        efd = 1'b0;
        d = 0;
        if (m >= GAP) begin
            q = (m - GAP) % PER;
            d = q / SLOT;
            sh = (q % SLOT) < DWELL;
            efd = (q == 0);
        end
`ifdef SEG_SCAN_MASK_EN
        sh = sh && en_mask[d];
`endif
        e_an = sh ? ~(4'(1) << d) : 4'hF;
        e_seg = sh ? m_disp[d] : 7'h7F;
        e_dp = sh ? ~m_ddp[d] : 1'b1;
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("dp", 32'(dp), 32'(e_dp));
        chk("frame_done", 32'(fd), 32'(efd));
        chk("in_ready", 32'(bus.in_ready), 32'(!m_full));
    endtask
    task automatic tick();
        logic v;
        logic [7*NDIG-1:0] sv;
        logic [NDIG-1:0] pv;
        v = bus.in_valid;
        sv = bus.in_seg;
        pv = bus.in_dp;
        @(posedge clk);
        if (rst) begin
            m = 0;
            m_full = 1'b0;
            for (int i = 0; i < NDIG; i++) m_disp[i] = 7'h7F;
            m_ddp = '0;
        end else begin
            m++;
            if (m >= GAP && (m - GAP) % PER == 0 && m_full) begin
                m_disp = m_pend;
                m_ddp = m_pdp;
                m_full = 1'b0;
            end else if (v && !m_full) begin
                for (int i = 0; i < NDIG; i++) m_pend[i] = sv[7*i +: 7];
                m_pdp = pv;
                m_full = 1'b1;
            end
        end
        #1;
        model_check();
    endtask
    task automatic drive(logic v, logic [7*NDIG-1:0] sv, logic [NDIG-1:0] pv);
        bus.in_valid = v;
        bus.in_seg = sv;
        bus.in_dp = pv;
    endtask
    task automatic wait_an(logic [3:0] v);
        for (int i = 0; i < 3 * PER && an !== v; i++) tick();
        chk("wait_an", 32'(an), 32'(v));
    endtask
    task automatic wait_fd();
        for (int i = 0; i < 3 * PER && fd !== 1'b1; i++) tick();
        chk("wait_frame_done", 32'(fd), 32'(1'b1));
    endtask
    initial begin
        vec_t tv [9];
        logic [27:0] fr_a, fr_b, fr_c, rs;
        logic [3:0] rp;
        int seen, bad;
        fr_a = {7'h40, 7'h79, 7'h24, 7'h30};
        fr_b = {7'h01, 7'h02, 7'h03, 7'h04};
        fr_c = {7'h11, 7'h22, 7'h33, 7'h44};
        tv = '{'{4'hF, 7'h7F, 1'b0, 1'b1}, '{4'hF, 7'h7F, 1'b0, 1'b1}, '{4'hE, 7'h7F, 1'b1, 1'b1},
               '{4'hE, 7'h7F, 1'b0, 1'b1}, '{4'hE, 7'h7F, 1'b0, 1'b1}, '{4'hE, 7'h7F, 1'b0, 1'b1},
               '{4'hF, 7'h7F, 1'b0, 1'b1}, '{4'hF, 7'h7F, 1'b0, 1'b1}, '{4'hD, 7'h7F, 1'b0, 1'b1}};
        drive(1'b0, '1, '0);
        repeat (3) tick();
        rst = 1'b0;
`ifndef SEG_SCAN_MASK_EN
        for (int i = 0; i < 9; i++) begin
            if (i > 0) tick();
            chk("vec_an", 32'(an), 32'(tv[i].an));
            chk("vec_seg", 32'(seg), 32'(tv[i].seg));
            chk("vec_fd", 32'(fd), 32'(tv[i].fd));
            chk("vec_rdy", 32'(bus.in_ready), 32'(tv[i].rdy));
        end
        drive(1'b1, fr_a, 4'b0001);
        tick();
        drive(1'b0, fr_a, 4'b0001);
        chk("load_rdy_low", 32'(bus.in_ready), 32'(1'b0));
        wait_fd();
        chk("a_d0_seg", 32'(seg), 32'(7'h30));
        chk("a_d0_dp", 32'(dp), 32'(1'b0));
        chk("a_rdy_after_commit", 32'(bus.in_ready), 32'(1'b1));
        wait_an(4'b1011);
        chk("a_d2_seg", 32'(seg), 32'(7'h79));
        wait_fd();
        wait_an(4'b1101);
        drive(1'b1, '1, '0);
        tick();
        drive(1'b0, '1, '0);
        wait_an(4'b1011);
        chk("mid_old_d2", 32'(seg), 32'(7'h79));
        wait_an(4'b0111);
        chk("mid_old_d3", 32'(seg), 32'(7'h40));
        wait_fd();
        chk("mid_new_d0", 32'(seg), 32'(7'h7F));
        drive(1'b1, fr_b, 4'b0010);
        tick();
        drive(1'b1, fr_c, 4'b0100);
        for (int i = 0; i < 2 * PER && bus.in_ready !== 1'b1; i++) tick();
        chk("b2b_rdy", 32'(bus.in_ready), 32'(1'b1));
        chk("b2b_fd", 32'(fd), 32'(1'b1));
        chk("b2b_b_d0", 32'(seg), 32'(7'h04));
        tick();
        drive(1'b0, fr_c, 4'b0100);
        chk("b2b_c_held", 32'(bus.in_ready), 32'(1'b0));
        repeat (PER - 1) tick();
        chk("c_fd_period", 32'(fd), 32'(1'b1));
        chk("c_d0", 32'(seg), 32'(7'h44));
        wait_an(4'b1011);
        drive(1'b1, fr_a, 4'b1111);
        tick();
        drive(1'b0, fr_a, 4'b1111);
        chk("pend_full", 32'(bus.in_ready), 32'(1'b0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_an", 32'(an), 32'(4'hF));
        chk("rst_seg", 32'(seg), 32'(7'h7F));
        chk("rst_rdy", 32'(bus.in_ready), 32'(1'b1));
        seen = 0;
        for (int i = 0; i < 2 * PER + GAP; i++) begin
            tick();
            if (seg !== 7'h7F) seen++;
        end
        chk("pending_dropped", 32'(seen), 32'(0));
`endif
        bad = 0;
        for (int i = 0; i < 1500; i++) begin
            rs = 28'($urandom);
            rp = 4'($urandom);
            drive($urandom_range(0, 3) == 0, rs, rp);
            rst = ($urandom_range(0, 299) == 0);
            tick();
            if (an !== 4'hF && an !== 4'b1110 && an !== 4'b1101 && an !== 4'b1011 && an !== 4'b0111) bad++;
`ifdef SEG_SCAN_MASK_EN
            if (an !== 4'hF && an !== 4'b1101 && an !== 4'b0111) bad++;
`endif
        end
        chk("an_legal", 32'(bad), 32'(0));
        rst = 1'b0;
        drive(1'b0, '1, '0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Time-multiplexed seven-segment display driver, directly downstream of the ALU's 7-segment decode stage.
- Accepts one frame of NDIG pre-decoded segment patterns plus decimal points over a valid/ready handshake.
- Holds the frame in a display register and scans digits one at a time onto a shared segment bus with per-digit select.
- Updates are applied only at frame boundaries, so a displayed frame never mixes old and new digits.

Parameters:
- NDIG, 8, number of digits scanned; legal range 2..16.
- DWELL, 1000, cycles each digit is driven per frame; must be >= 1.
- GAP, 16, all-off cycles between digits (ghosting guard); must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream frame valid.
- in_ready  output  1  frame can be accepted.
- in_seg  input  7*NDIG  segment codes, active-low gfedcba; digit i at bits [7i+6:7i].
- in_dp  input  NDIG  decimal points, active-high, bit i = digit i.
- an  output  NDIG  digit select, active-low one-hot (all ones = none).
- seg  output  7  segment bus, active-low, passed through unchanged.
- dp  output  1  decimal point, active-low.
- frame_done  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- All outputs are registered. Clock is clk; reset is rst, synchronous and active-high.
- Reset values:
  - an = all ones, seg = 7'h7F, dp = 1, in_ready = 1, frame_done = 0.
  - Display register = all-blank (7'h7F per digit, dp off); pending register empty.
  - FSM = BLANK, digit index = NDIG-1, phase counter = 0.
- FSM states:
  - SHOW: an = ~(1<<idx), seg = disp_seg[idx], dp = ~disp_dp[idx], held for DWELL cycles, then go to BLANK.
  - BLANK: an = all ones, seg = 7'h7F, dp = 1, held for GAP cycles. Then idx = (idx+1) mod NDIG and go to SHOW.
- Frame boundary: the BLANK->SHOW transition where idx wraps from NDIG-1 to 0.
  - frame_done pulses for exactly one cycle, aligned with the first SHOW cycle of digit 0.
- First SHOW of digit 0 after reset starts GAP cycles after the first cycle with rst low.
- Frame period = NDIG*(DWELL+GAP) cycles.
- Handshake:
  - A transfer occurs on an edge with in_valid && in_ready. in_seg and in_dp are captured into the pending register.
  - in_ready goes low the following cycle.
  - in_valid while in_ready is low has no effect; upstream must hold its data.
- Commit:
  - At a frame boundary with pending full, pending is copied into the display register.
  - The new values drive the SHOW of digit 0 on that same boundary; pending is cleared.
  - in_ready returns high on the cycle after commit.
  - A transfer and a commit can never coincide, because in_ready is low whenever pending is full.
- A transfer that lands on the boundary cycle itself is committed at the next boundary.
- Reset asserted mid-frame:
  - Every state element returns to its reset value on that edge.
  - Pending data is discarded and the display goes blank.
- Width of the phase counter is sized internally to hold max(DWELL, GAP)-1. It never overflows.

Optional Feature:
- Macro: SEG_SCAN_MASK_EN.
- Defined:
  - Adds input en_mask[NDIG-1:0], sampled each cycle.
  - A digit whose mask bit is 0 keeps its full SHOW slot timing, but an stays all ones and seg/dp stay off during that slot.
  - Frame period is unchanged.
- Undefined: no en_mask port; all digits are always enabled.

Test Plan (NDIG=4, DWELL=4, GAP=2, frame period 24 cycles):
- Reset, idle inputs -> an=4'hF, seg=7'h7F, in_ready=1 during reset. an=4'b1110 with seg=7'h7F first appears on the 3rd cycle after rst falls, together with a frame_done pulse.
- Load in_seg={7'h40,7'h79,7'h24,7'h30} with in_dp=4'b0001 -> in_ready low until the next boundary. Then:
  - digit0 shows 7'h30 with dp=0 for 4 cycles, then 2 blank cycles;
  - digit1 shows 7'h24, digit2 shows 7'h79, digit3 shows 7'h40;
  - in_ready is high 1 cycle after the boundary.
- Mid-frame load of 7'h7F codes while digit1 is showing -> digits 2 and 3 of the current frame still show the old codes. Blank codes start at the next frame_done.
- Back-to-back in_valid with two different frames -> the second is held off (in_ready=0) and accepted the cycle after the first commit. It is displayed one frame (24 cycles) later.
- rst pulse during SHOW of digit2 with pending full -> next cycle an=4'hF, seg=7'h7F, in_ready=1. After restart, a blank frame is shown and the pending data never appears.
- SEG_SCAN_MASK_EN defined, en_mask=4'b1010 -> an only ever takes the values 4'b1101 and 4'b0111. frame_done period stays 24 cycles.
